// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES input loader
package aes_pkg;

  typedef enum logic [1:0] {
    LOAD_KEY = 2'd0,
    LOAD_BLK = 2'd1,
    READY    = 2'd2
  } state_e;

  localparam int BLK_BYTES     = 16;
  localparam int KEY_BYTES_128 = 16;
  localparam int KEY_BYTES_192 = 24;
  localparam int KEY_BYTES_256 = 32;

  function automatic bit key_bytes_legal(input int kb);
    return (kb == KEY_BYTES_128) || (kb == KEY_BYTES_192) || (kb == KEY_BYTES_256);
  endfunction

endpackage

// File: rtl/byte_shift_reg.sv
// rtl/byte_shift_reg.sv - load-enabled left shift register, one byte per load
module byte_shift_reg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [7:0]   din,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // New bytes enter at the LSB end so the first byte ends up on top.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = {data_q[W-9:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/aes_input_loader.sv
// rtl/aes_input_loader.sv - byte-serial key/block assembler for the AES-256 core
module aes_input_loader
  import aes_pkg::*;
#(
  parameter int KEY_BYTES = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   key_reload,
  input  logic                   out_ack,
  output logic                   out_valid,
  output logic [127:0]           In,
  output logic [8*KEY_BYTES-1:0] Key,
  output logic                   key_loaded,
  output logic [4:0]             byte_cnt
);

  localparam int KEY_BITS = 8 * KEY_BYTES;

  if (!key_bytes_legal(KEY_BYTES)) begin : g_bad_key_bytes
    $error("aes_input_loader: KEY_BYTES must be 16, 24 or 32");
  end

  state_e     state_d, state_q;
  logic [4:0] byte_cnt_d, byte_cnt_q;
  logic       key_loaded_d, key_loaded_q;
  logic       out_valid_d, out_valid_q;
  logic       xfer;
  logic       key_load;
  logic       blk_load;

  assign in_ready = (state_q != READY);
  assign xfer     = in_valid && in_ready;
  assign key_load = xfer && (state_q == LOAD_KEY);
  assign blk_load = xfer && (state_q == LOAD_BLK);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    key_loaded_d = key_loaded_q;
    out_valid_d  = out_valid_q;
    case (state_q)
      LOAD_KEY: begin
        if (xfer) begin
          if (byte_cnt_q == 5'(KEY_BYTES - 1)) begin
            byte_cnt_d   = '0;
            key_loaded_d = 1'b1;
            state_d      = LOAD_BLK;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      LOAD_BLK: begin
        if (xfer) begin
          if (byte_cnt_q == 5'(BLK_BYTES - 1)) begin
            byte_cnt_d  = '0;
            out_valid_d = 1'b1;
            state_d     = READY;
          end else begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
        end
      end
      READY: begin
        // Old Key stays visible during a reload until bytes overwrite it.
        if (out_ack) begin
          out_valid_d = 1'b0;
          if (key_reload) begin
            key_loaded_d = 1'b0;
            state_d      = LOAD_KEY;
          end else begin
            state_d = LOAD_BLK;
          end
        end
      end
      default: begin
        state_d = LOAD_KEY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD_KEY;
      byte_cnt_q   <= '0;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      key_loaded_q <= key_loaded_d;
      out_valid_q  <= out_valid_d;
    end
  end

  byte_shift_reg #(.W(KEY_BITS)) u_key_reg (
    .clk  (clk),
    .clr  (rst),
    .load (key_load),
    .din  (in_byte),
    .q    (Key)
  );

  byte_shift_reg #(.W(128)) u_blk_reg (
    .clk  (clk),
    .clr  (rst),
    .load (blk_load),
    .din  (in_byte),
    .q    (In)
  );

  assign out_valid  = out_valid_q;
  assign key_loaded = key_loaded_q;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_aes_input_loader.sv
// tb/tb_aes_input_loader.sv - scoreboard bench for aes_input_loader
module tb_aes_input_loader;

  localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_B = 128'hffeeddccbbaa99887766554433221100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_byte = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         key_reload = 1'b0;
  logic         out_ack = 1'b0;
  logic         out_valid;
  logic [127:0] blk_out;
  logic [255:0] key_out;
  logic         key_loaded;
  logic [4:0]   byte_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [127:0] blk;
    logic [255:0] key;
    int           xfers;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  aes_input_loader #(.KEY_BYTES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .key_reload (key_reload),
    .out_ack    (out_ack),
    .out_valid  (out_valid),
    .In         (blk_out),
    .Key        (key_out),
    .key_loaded (key_loaded),
    .byte_cnt   (byte_cnt)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Monitor: counts transfers and checks each completed load against the scoreboard.
  int   xfer_cnt = 0;
  logic prev_ov  = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 256'(out_valid), 256'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_in", 256'(blk_out), 256'(e.blk));
        check("sb_key", key_out, e.key);
        check("sb_xfers", 256'(xfer_cnt), 256'(e.xfers));
      end
    end
    if (out_valid && !prev_ov) begin
      check("ready_low_in_ready", 256'(in_ready), 256'(0));
    end
    prev_ov = out_valid;
    if (rst) begin
      xfer_cnt = 0;
    end else begin
      if (in_valid && in_ready) xfer_cnt++;
      if (out_valid && out_ack) xfer_cnt = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int pct);
    bit accepted = 0;
    int n = 0;
    while (!accepted && n < 2000) begin
      in_byte  = b;
      in_valid = (pct >= 100) || ($urandom_range(99) < pct);
      accepted = in_valid && in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!accepted) check("send_timeout", 256'(0), 256'(1));
  endtask

  task automatic send_vec(input logic [255:0] w, input int nbytes, input int pct);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(w[8*(nbytes-1-i) +: 8], pct);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) check("wait_out_valid_timeout", 256'(0), 256'(1));
  endtask

  task automatic do_ack(input logic reload);
    wait_valid();
    out_ack    = 1'b1;
    key_reload = reload;
    @(posedge clk);
    #1;
    out_ack    = 1'b0;
    key_reload = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in"}, 256'(blk_out), 256'(0));
    check({tag, "_key"}, key_out, 256'(0));
    check({tag, "_byte_cnt"}, 256'(byte_cnt), 256'(0));
    check({tag, "_key_loaded"}, 256'(key_loaded), 256'(0));
    check({tag, "_out_valid"}, 256'(out_valid), 256'(0));
    check({tag, "_in_ready"}, 256'(in_ready), 256'(1));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // FIPS-197 C.3 load, in_valid held high
    exp_q.push_back('{blk: BLK_A, key: KEY_A, xfers: 48});
    send_vec(KEY_A, 32, 100);
    send_vec(256'(BLK_A), 16, 100);
    wait_valid();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_in_ready", 256'(in_ready), 256'(0));
      check("hold_out_valid", 256'(out_valid), 256'(1));
    end
    do_ack(1'b0);

    // Same-key reuse
    exp_q.push_back('{blk: BLK_B, key: KEY_A, xfers: 16});
    for (int i = 0; i < 16; i++) begin
      send_byte(BLK_B[8*(15-i) +: 8], 100);
      check("reuse_key_loaded", 256'(key_loaded), 256'(1));
    end
    in_valid = 1'b0;
    wait_valid();
    do_ack(1'b1);

    // Key reload with byte_cnt tracking
    exp_q.push_back('{blk: BLK_A, key: KEY_B, xfers: 48});
    check("reload_old_key_held", key_out, KEY_A);
    for (int i = 0; i < 32; i++) begin
      check("reload_byte_cnt", 256'(byte_cnt), 256'(i));
      check("reload_key_loaded", 256'(key_loaded), 256'(0));
      send_byte(KEY_B[8*(31-i) +: 8], 100);
    end
    in_valid = 1'b0;
    check("reload_new_key", key_out, KEY_B);
    check("reload_key_loaded_done", 256'(key_loaded), 256'(1));
    check("reload_cnt_cleared", 256'(byte_cnt), 256'(0));
    send_vec(256'(BLK_A), 16, 100);
    wait_valid();
    do_ack(1'b1);

    // Gapped source at ~30% duty
    exp_q.push_back('{blk: BLK_A, key: KEY_A, xfers: 48});
    send_vec(KEY_A, 32, 30);
    send_vec(256'(BLK_A), 16, 30);
    wait_valid();

    // Backpressure: a5 offered during READY must not be taken
    in_byte  = 8'ha5;
    in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    check("bp_in_frozen", 256'(blk_out), 256'(BLK_A));
    check("bp_key_frozen", key_out, KEY_A);
    check("bp_cnt", 256'(byte_cnt), 256'(0));
    do_ack(1'b0);
    check("bp_in_ready_after_ack", 256'(in_ready), 256'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_first_byte", 256'(blk_out[7:0]), 256'(8'ha5));
    check("bp_first_cnt", 256'(byte_cnt), 256'(1));

    // Reset mid key load
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_vec(KEY_A, 20, 100);
    check("pre_reset_cnt", 256'(byte_cnt), 256'(20));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("midreset");
    exp_q.push_back('{blk: BLK_A, key: KEY_A, xfers: 48});
    send_vec(KEY_A, 32, 100);
    send_vec(256'(BLK_A), 16, 100);
    wait_valid();
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
